// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite row fetcher and serialiser: decides coverage on line_start, reads one ROM
// row, then shifts it out on pixel_on starting the cycle after hpos reaches the sprite's left edge.
//
// state   | meaning
// IDLE    | nothing to draw on this line
// FETCH   | ROM read strobe asserted (one cycle)
// CAPTURE | ROM row available, loaded into the shift register
// ARMED   | waiting for hpos to equal the latched sprite_x
// DRAW    | serialising the row, 2^SCALE_LOG2 cycles per sprite pixel
module sprite_line_renderer #(
  parameter int COORD_W    = 10,
  parameter int SCALE_LOG2 = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               line_start,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [3:0]         sprite_id,
  input  logic [1:0]         sprite_dir,
  output logic               rom_read_enable,
  output logic [3:0]         rom_sprite_ID,
  output logic [1:0]         rom_orientation,
  output logic [2:0]         rom_line_index,
  input  logic [7:0]         rom_data,
  output logic               pixel_on,
  output logic               busy
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ARMED, DRAW} state_t;

  localparam logic [COORD_W-1:0] ROW_LIMIT = COORD_W'(8 << SCALE_LOG2);
  localparam logic [2:0]         SUB_MAX   = 3'((1 << SCALE_LOG2) - 1);

  state_t             state_q, state_d;
  logic [3:0]         id_q, id_d;
  logic [1:0]         dir_q, dir_d;
  logic [2:0]         idx_q, idx_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [2:0]         pix_q, pix_d;
  logic [2:0]         sub_q, sub_d;

  logic [COORD_W-1:0] row;
  logic               row_hit;
  logic [2:0]         row_idx;

  // Rows above sprite_y wrap to large values and fall outside ROW_LIMIT.
  assign row     = vpos - sprite_y;
  assign row_hit = (row < ROW_LIMIT);
  assign row_idx = 3'(row >> SCALE_LOG2);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    x_d     = x_q;
    shreg_d = shreg_q;
    pix_d   = pix_q;
    sub_d   = sub_q;

    case (state_q)
      IDLE:    ;
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        shreg_d = rom_data;
        state_d = ARMED;
      end
      ARMED: begin
        if (hpos == x_q) begin
          state_d = DRAW;
          pix_d   = 3'd0;
          sub_d   = 3'd0;
        end
      end
      DRAW: begin
        if (sub_q == SUB_MAX) begin
          sub_d   = 3'd0;
          shreg_d = {shreg_q[6:0], 1'b1};
          pix_d   = pix_q + 3'd1;
          if (pix_q == 3'd7) state_d = IDLE;
        end else begin
          sub_d = sub_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new scanline overrides whatever was in progress.
    if (line_start) begin
      if (enable && row_hit) begin
        id_d    = sprite_id;
        dir_d   = sprite_dir;
        idx_d   = row_idx;
        x_d     = sprite_x;
        state_d = FETCH;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= 4'd0;
      dir_q   <= 2'd0;
      idx_q   <= 3'd0;
      x_q     <= '0;
      shreg_q <= 8'hFF;
      pix_q   <= 3'd0;
      sub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      shreg_q <= shreg_d;
      pix_q   <= pix_d;
      sub_q   <= sub_d;
    end
  end

  assign rom_read_enable = (state_q == FETCH);
  assign rom_sprite_ID   = id_q;
  assign rom_orientation = dir_q;
  assign rom_line_index  = idx_q;
  assign pixel_on        = (state_q == DRAW) && !shreg_q[7];
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer: two instances (SCALE_LOG2 = 0 and 1) share stimulus and are
// checked per cycle against a timeline model of each scanline plus a small registered ROM model.
module tb_sprite_line_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       line_start;
  logic [9:0] hpos, vpos, sprite_x, sprite_y;
  logic [3:0] sprite_id;
  logic [1:0] sprite_dir;

  logic [1:0] re, pix_on, busy;
  logic [3:0] rom_id  [2];
  logic [1:0] rom_or  [2];
  logic [2:0] rom_li  [2];
  logic [7:0] rom_dat [2];

  logic [7:0] rom_mem [9][4][8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_line_renderer #(.COORD_W(10), .SCALE_LOG2(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .line_start(line_start),
    .hpos(hpos), .vpos(vpos), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_id(sprite_id), .sprite_dir(sprite_dir),
    .rom_read_enable(re[0]), .rom_sprite_ID(rom_id[0]), .rom_orientation(rom_or[0]),
    .rom_line_index(rom_li[0]), .rom_data(rom_dat[0]),
    .pixel_on(pix_on[0]), .busy(busy[0]));

  sprite_line_renderer #(.COORD_W(10), .SCALE_LOG2(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .line_start(line_start),
    .hpos(hpos), .vpos(vpos), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_id(sprite_id), .sprite_dir(sprite_dir),
    .rom_read_enable(re[1]), .rom_sprite_ID(rom_id[1]), .rom_orientation(rom_or[1]),
    .rom_line_index(rom_li[1]), .rom_data(rom_dat[1]),
    .pixel_on(pix_on[1]), .busy(busy[1]));

  function automatic logic [7:0] rom_lookup(input logic [3:0] id, input logic [1:0] dir,
                                            input logic [2:0] idx);
    if (id > 4'd8) return 8'hFF;
    return rom_mem[id][dir][idx];
  endfunction

  // Registered ROM: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (re[0]) rom_dat[0] <= rom_lookup(rom_id[0], rom_or[0], rom_li[0]);
    if (re[1]) rom_dat[1] <= rom_lookup(rom_id[1], rom_or[1], rom_li[1]);
  end

  // One scanline: line_start in cycle 0, hpos = h0 + c in cycle c, cycles 1..ncyc checked.
  task automatic run_line(input bit en, input logic [9:0] vp, input logic [9:0] sy,
                          input logic [9:0] sx, input logic [9:0] h0, input logic [3:0] id,
                          input logic [1:0] dir, input int ncyc,
                          output logic [7:0] cap0, output logic [2:0] fetch_idx1);
    bit         hit [2];
    logic [2:0] idx [2];
    logic [7:0] dat [2];
    int         t   [2];
    logic [9:0] row;
    row = vp - sy;
    for (int s = 0; s < 2; s++) begin
      hit[s] = en && (int'(row) < (8 << s));
      idx[s] = 3'(row >> s);
      dat[s] = rom_lookup(id, dir, idx[s]);
      t[s]   = -1;
      for (int c = 3; c <= ncyc; c++)
        if (t[s] < 0 && 10'(h0 + 10'(c)) == sx) t[s] = c;
    end
    cap0 = 8'h00;
    fetch_idx1 = 3'd0;

    @(posedge clk); #1;
    enable = en; vpos = vp; sprite_y = sy; sprite_x = sx;
    sprite_id = id; sprite_dir = dir; hpos = h0; line_start = 1'b1;

    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      line_start = 1'b0;
      hpos = 10'(h0 + 10'(c));
      @(negedge clk);
      if (c == 1) fetch_idx1 = rom_li[1];
      if (t[0] >= 0 && c > t[0] && c <= t[0] + 8) cap0 = {cap0[6:0], pix_on[0]};
      for (int s = 0; s < 2; s++) begin
        logic exp_re, exp_busy, exp_pix;
        int   len;
        len      = 8 << s;
        exp_re   = hit[s] && (c == 1);
        exp_busy = 1'b0;
        exp_pix  = 1'b0;
        if (hit[s]) begin
          if (t[s] < 0) exp_busy = 1'b1;
          else begin
            exp_busy = (c <= t[s] + len);
            if (c > t[s] && c <= t[s] + len) exp_pix = ~dat[s][7 - ((c - t[s] - 1) >> s)];
          end
        end
        n_checks++;
        if (re[s] !== exp_re) begin
          n_fail++;
          $display("FAIL rd_strobe dut%0d cyc %0d: got %b expected %b", s, c, re[s], exp_re);
        end
        n_checks++;
        if (busy[s] !== exp_busy) begin
          n_fail++;
          $display("FAIL busy dut%0d cyc %0d: got %b expected %b", s, c, busy[s], exp_busy);
        end
        n_checks++;
        if (pix_on[s] !== exp_pix) begin
          n_fail++;
          $display("FAIL pixel_on dut%0d cyc %0d: got %b expected %b", s, c, pix_on[s], exp_pix);
        end
        if (hit[s] && (c == 1 || c == 2)) begin
          n_checks++;
          if (rom_id[s] !== id || rom_or[s] !== dir || rom_li[s] !== idx[s]) begin
            n_fail++;
            $display("FAIL rom_sel dut%0d cyc %0d: got id=%0d dir=%0d idx=%0d expected id=%0d dir=%0d idx=%0d",
                     s, c, rom_id[s], rom_or[s], rom_li[s], id, dir, idx[s]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; line_start = 1'b1;
    vpos = 10'd103; sprite_y = 10'd100; sprite_x = 10'd5; hpos = 10'd0;
    sprite_id = 4'd1; sprite_dir = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (re !== 2'b00 || pix_on !== 2'b00 || busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_outputs clk %0d: got re=%b pix=%b busy=%b expected all 0", i, re, pix_on, busy);
      end
      n_checks++;
      if (rom_id[0] !== 4'd0 || rom_or[0] !== 2'd0 || rom_li[0] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_rom_sel: got id=%0d dir=%0d idx=%0d expected 0", rom_id[0], rom_or[0], rom_li[0]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1; line_start = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] cap; logic [2:0] fi;
    rom_mem[0][0][3] = 8'hC0;
    run_line(1'b1, 10'd103, 10'd100, 10'd200, 10'd196, 4'd0, 2'd0, 30, cap, fi);
    n_checks++;
    if (cap !== 8'h3F) begin
      n_fail++;
      $display("FAIL basic_row_pattern: got %b expected 00111111", cap);
    end
  endtask

  task automatic test_scale2();
    logic [7:0] cap; logic [2:0] fi;
    run_line(1'b1, 10'd55, 10'd50, 10'd300, 10'd293, 4'd3, 2'd2, 30, cap, fi);
    n_checks++;
    if (fi !== 3'd2) begin
      n_fail++;
      $display("FAIL scale2_line_index: got %0d expected 2", fi);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] cap; logic [2:0] fi;
    run_line(1'b1, 10'd99,  10'd100, 10'd40, 10'd35, 4'd2, 2'd1, 20, cap, fi);
    run_line(1'b1, 10'd108, 10'd100, 10'd40, 10'd35, 4'd2, 2'd1, 30, cap, fi);
    run_line(1'b1, 10'd1,   10'd1020, 10'd40, 10'd35, 4'd2, 2'd1, 30, cap, fi);
  endtask

  task automatic test_abort();
    logic [7:0] cap; logic [2:0] fi;
    run_line(1'b1, 10'd12, 10'd10, 10'd100, 10'd95, 4'd4, 2'd0, 8, cap, fi);
    run_line(1'b1, 10'd13, 10'd10, 10'd150, 10'd144, 4'd5, 2'd3, 30, cap, fi);
  endtask

  task automatic test_disabled();
    logic [7:0] cap; logic [2:0] fi;
    run_line(1'b0, 10'd202, 10'd200, 10'd60, 10'd55, 4'd1, 2'd0, 25, cap, fi);
  endtask

  task automatic test_orientation();
    logic [7:0] cap; logic [2:0] fi;
    run_line(1'b1, 10'd402, 10'd400, 10'd80, 10'd74, 4'd6, 2'd1, 30, cap, fi);
  endtask

  task automatic test_reset_mid();
    logic [7:0] cap; logic [2:0] fi;
    run_line(1'b1, 10'd32, 10'd30, 10'd500, 10'd495, 4'd7, 2'd2, 7, cap, fi);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (re !== 2'b00 || pix_on !== 2'b00 || busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_op: got re=%b pix=%b busy=%b expected all 0", re, pix_on, busy);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] cap; logic [2:0] fi;
    for (int n = 0; n < 25; n++) begin
      logic [9:0] sy, vp, sx, h0;
      bit en;
      int ncyc;
      sy   = 10'($urandom);
      vp   = 10'(sy + 10'($urandom_range(0, 22)) - 10'd3);
      sx   = 10'($urandom);
      h0   = 10'(sx - 10'($urandom_range(0, 9)));
      en   = ($urandom_range(0, 7) != 0);
      ncyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 20)) : 30;
      run_line(en, vp, sy, sx, h0, 4'($urandom_range(0, 15)), 2'($urandom), ncyc, cap, fi);
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++)
      for (int d = 0; d < 4; d++)
        for (int r = 0; r < 8; r++)
          rom_mem[i][d][r] = 8'($urandom);
    test_reset();
    test_basic();
    test_scale2();
    test_out_of_range();
    test_abort();
    test_disabled();
    test_orientation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
